rw_control_sequencer: RTL and testbench

//  Bus-side sequencer for the 8254: decodes CPU strobes per address, holds each counter's

---
 rtl/rw_control_sequencer.sv | 159 +++++++++++++++
 tb/tb_rw_control_sequencer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/rw_control_sequencer.sv
// Bus-side sequencer for an 8254-style timer: decodes CPU accesses, keeps per-counter
// control words, sequences byte-wide loads/reads and handles counter-latch commands.
module rw_control_sequencer #(
    parameter int         DW     = 8,
    parameter logic [1:0] RST_RW = 2'b11
) (
    input  logic            CLK,
    input  logic            RESET_N,
    input  logic            CS_N,
    input  logic            RD_N,
    input  logic            WR_N,
    input  logic [1:0]      A,
    input  logic [DW-1:0]   DIN,
    input  logic [6*DW-1:0] CNT_IN,
    output logic [DW-1:0]   DOUT,
    output logic            DOUT_EN,
    output logic [8:0]      MODE,
    output logic [2:0]      BCD,
    output logic [2:0]      CFG_STB,
    output logic [2:0]      LOAD_STB,
    output logic [2*DW-1:0] LOAD_VAL
);

    logic            rd_q;
    logic            wr_q;
    logic            rd_fire;
    logic            wr_fire;
    logic [1:0]      rw        [3];
    logic [2:0]      mode      [3];
    logic [2:0]      wptr;
    logic [2:0]      rptr;
    logic [2:0]      latched;
    logic [2*DW-1:0] latch_val [3];
    logic [DW-1:0]   hold      [3];

    logic [1:0]      sc;
    logic [1:0]      crw;
    logic [2:0]      cm;
    logic [2*DW-1:0] rd_word;
    logic            rd_msb;
    logic            rd_release;
    logic [DW-1:0]   rd_byte;

    // An access fires on the first sampled-low cycle of a strobe; simultaneous strobes are void.
    assign rd_fire = !CS_N && !RD_N && rd_q && WR_N;
    assign wr_fire = !CS_N && !WR_N && wr_q && RD_N;

    assign sc   = DIN[7:6];
    assign crw  = DIN[5:4];
    assign cm   = DIN[3:1];
    assign MODE = {mode[2], mode[1], mode[0]};

    always_comb begin
        rd_word    = '0;
        rd_msb     = 1'b0;
        rd_release = 1'b0;
        for (int n = 0; n < 3; n++) begin
            if (A == 2'(n)) begin
                rd_word = latched[n] ? latch_val[n] : CNT_IN[n*2*DW +: 2*DW];
                case (rw[n])
                    2'b01: begin
                        rd_msb     = 1'b0;
                        rd_release = 1'b1;
                    end
                    2'b10: begin
                        rd_msb     = 1'b1;
                        rd_release = 1'b1;
                    end
                    default: begin
                        rd_msb     = rptr[n];
                        rd_release = rptr[n];
                    end
                endcase
            end
        end
        rd_byte = rd_msb ? rd_word[2*DW-1:DW] : rd_word[DW-1:0];
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            rd_q     <= 1'b1;
            wr_q     <= 1'b1;
            DOUT     <= '0;
            DOUT_EN  <= 1'b0;
            BCD      <= '0;
            CFG_STB  <= '0;
            LOAD_STB <= '0;
            LOAD_VAL <= '0;
            wptr     <= '0;
            rptr     <= '0;
            latched  <= '0;
            for (int n = 0; n < 3; n++) begin
                rw[n]        <= RST_RW;
                mode[n]      <= '0;
                latch_val[n] <= '0;
                hold[n]      <= '0;
            end
        end else begin
            rd_q     <= RD_N;
            wr_q     <= WR_N;
            CFG_STB  <= '0;
            LOAD_STB <= '0;
            DOUT_EN  <= DOUT_EN && !RD_N && !CS_N;

            for (int n = 0; n < 3; n++) begin
                // Control word; SC=3 (read-back) never matches a counter and is dropped.
                if (wr_fire && A == 2'd3 && sc == 2'(n)) begin
                    if (crw == 2'b00) begin
                        if (!latched[n]) begin
                            latched[n]   <= 1'b1;
                            latch_val[n] <= CNT_IN[n*2*DW +: 2*DW];
                        end
                    end else begin
                        rw[n]      <= crw;
                        mode[n]    <= (cm[2] && cm[1]) ? {1'b0, cm[1:0]} : cm;
                        BCD[n]     <= DIN[0];
                        wptr[n]    <= 1'b0;
                        rptr[n]    <= 1'b0;
                        latched[n] <= 1'b0;
                        CFG_STB[n] <= 1'b1;
                    end
                end

                if (wr_fire && A == 2'(n)) begin
                    case (rw[n])
                        2'b01: begin
                            LOAD_VAL    <= {{DW{1'b0}}, DIN};
                            LOAD_STB[n] <= 1'b1;
                        end
                        2'b10: begin
                            LOAD_VAL    <= {DIN, {DW{1'b0}}};
                            LOAD_STB[n] <= 1'b1;
                        end
                        default: begin
                            if (!wptr[n]) begin
                                hold[n] <= DIN;
                                wptr[n] <= 1'b1;
                            end else begin
                                LOAD_VAL    <= {DIN, hold[n]};
                                LOAD_STB[n] <= 1'b1;
                                wptr[n]     <= 1'b0;
                            end
                        end
                    endcase
                end

                if (rd_fire && A == 2'(n)) begin
                    DOUT    <= rd_byte;
                    DOUT_EN <= 1'b1;
                    if (rw[n] == 2'b11)
                        rptr[n] <= !rptr[n];
                    if (rd_release)
                        latched[n] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_rw_control_sequencer.sv
// Scoreboard bench for rw_control_sequencer: directed bus accesses queue expected
// strobe/read events; a negedge monitor pops and compares them as the DUT emits them.
module tb_rw_control_sequencer;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic        CS_N;
    logic        RD_N;
    logic        WR_N;
    logic [1:0]  A;
    logic [7:0]  DIN;
    logic [47:0] CNT_IN;
    logic [7:0]  DOUT;
    logic        DOUT_EN;
    logic [8:0]  MODE;
    logic [2:0]  BCD;
    logic [2:0]  CFG_STB;
    logic [2:0]  LOAD_STB;
    logic [15:0] LOAD_VAL;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string       name;
        logic [2:0]  cfg;
        logic [2:0]  load;
        logic [15:0] lval;
        logic        rd;
        logic [7:0]  dout;
    } exp_t;

    exp_t exp_q[$];

    rw_control_sequencer #(.DW(8), .RST_RW(2'b11)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .CS_N(CS_N), .RD_N(RD_N), .WR_N(WR_N),
        .A(A), .DIN(DIN), .CNT_IN(CNT_IN), .DOUT(DOUT), .DOUT_EN(DOUT_EN),
        .MODE(MODE), .BCD(BCD), .CFG_STB(CFG_STB), .LOAD_STB(LOAD_STB),
        .LOAD_VAL(LOAD_VAL)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic push_exp(input string name, input logic [2:0] cfg, input logic [2:0] load,
                            input logic [15:0] lval, input logic rd, input logic [7:0] dout);
        exp_t e;
        e.name = name; e.cfg = cfg; e.load = load; e.lval = lval; e.rd = rd; e.dout = dout;
        exp_q.push_back(e);
    endtask

    // Monitor: each strobe cycle or DOUT_EN rising edge is one observed event.
    initial begin
        logic den_prev;
        logic rd_ev;
        exp_t e;
        den_prev = 1'b0;
        forever begin
            @(negedge CLK);
            rd_ev = DOUT_EN && !den_prev;
            if (RESET_N && (CFG_STB != 3'b0 || LOAD_STB != 3'b0 || rd_ev)) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_event: cfg=%b load=%b lval=%h rd=%b dout=%h, none expected",
                             CFG_STB, LOAD_STB, LOAD_VAL, rd_ev, DOUT);
                end else begin
                    e = exp_q.pop_front();
                    check({e.name, "_cfg"}, {29'b0, CFG_STB}, {29'b0, e.cfg});
                    check({e.name, "_load"}, {29'b0, LOAD_STB}, {29'b0, e.load});
                    check({e.name, "_rd"}, {31'b0, rd_ev}, {31'b0, e.rd});
                    if (e.load != 3'b0) check({e.name, "_lval"}, {16'b0, LOAD_VAL}, {16'b0, e.lval});
                    if (e.rd) check({e.name, "_dout"}, {24'b0, DOUT}, {24'b0, e.dout});
                end
            end
            den_prev = DOUT_EN;
        end
    end

    task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
        @(posedge CLK); #1;
        A = a; DIN = d; CS_N = 1'b0; WR_N = 1'b0;
        repeat (2) @(posedge CLK);
        #1; WR_N = 1'b1; CS_N = 1'b1;
    endtask

    task automatic bus_read(input logic [1:0] a);
        @(posedge CLK); #1;
        A = a; CS_N = 1'b0; RD_N = 1'b0;
        repeat (2) @(posedge CLK);
        #1; RD_N = 1'b1; CS_N = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_dout"}, {24'b0, DOUT}, 32'h0);
        check({tag, "_dout_en"}, {31'b0, DOUT_EN}, 32'h0);
        check({tag, "_mode"}, {23'b0, MODE}, 32'h0);
        check({tag, "_bcd"}, {29'b0, BCD}, 32'h0);
        check({tag, "_cfg_stb"}, {29'b0, CFG_STB}, 32'h0);
        check({tag, "_load_stb"}, {29'b0, LOAD_STB}, 32'h0);
        check({tag, "_load_val"}, {16'b0, LOAD_VAL}, 32'h0);
    endtask

    initial begin
        RESET_N = 1'b0; CS_N = 1'b1; RD_N = 1'b1; WR_N = 1'b1;
        A = 2'd0; DIN = 8'h00; CNT_IN = 48'h0;
        repeat (3) @(posedge CLK);
        #1;
        check_reset_outputs("reset");
        RESET_N = 1'b1;

        // Reset RW is LSB-then-MSB on every counter.
        bus_write(2'd1, 8'h11);
        push_exp("rst_rw_load", 3'b000, 3'b010, 16'h2211, 1'b0, 8'h00);
        bus_write(2'd1, 8'h22);

        // Counter 0: RW=11, mode 2, two-byte load.
        push_exp("cfg0_34", 3'b001, 3'b000, 16'h0, 1'b0, 8'h00);
        bus_write(2'd3, 8'h34);
        check("mode0_after_34", {29'b0, MODE[2:0]}, 32'd2);
        bus_write(2'd0, 8'h34);
        push_exp("load0_1234", 3'b000, 3'b001, 16'h1234, 1'b0, 8'h00);
        bus_write(2'd0, 8'h12);

        // Counter 1: LSB only, mode 6 folds to 2.
        push_exp("cfg1_5c", 3'b010, 3'b000, 16'h0, 1'b0, 8'h00);
        bus_write(2'd3, 8'h5C);
        check("mode1_after_5c", {29'b0, MODE[5:3]}, 32'd2);
        check("bcd1_after_5c", {31'b0, BCD[1]}, 32'd0);
        push_exp("load1_00ab", 3'b000, 3'b010, 16'h00AB, 1'b0, 8'h00);
        bus_write(2'd1, 8'hAB);

        // Counter 2: RW=11, mode 3, BCD.
        push_exp("cfg2_b7", 3'b100, 3'b000, 16'h0, 1'b0, 8'h00);
        bus_write(2'd3, 8'hB7);
        check("mode2_after_b7", {29'b0, MODE[8:6]}, 32'd3);
        check("bcd2_after_b7", {31'b0, BCD[2]}, 32'd1);

        // Latch on counter 2; second latch command must not recapture.
        CNT_IN[32 +: 16] = 16'hBEEF;
        bus_write(2'd3, 8'h80);
        CNT_IN[32 +: 16] = 16'h0001;
        bus_write(2'd3, 8'h80);
        check("mode2_after_latch", {29'b0, MODE[8:6]}, 32'd3);
        push_exp("rd2_latch_lsb", 3'b000, 3'b000, 16'h0, 1'b1, 8'hEF);
        bus_read(2'd2);
        push_exp("rd2_latch_msb", 3'b000, 3'b000, 16'h0, 1'b1, 8'hBE);
        bus_read(2'd2);
        push_exp("rd2_live_lsb", 3'b000, 3'b000, 16'h0, 1'b1, 8'h01);
        bus_read(2'd2);
        push_exp("rd2_live_msb", 3'b000, 3'b000, 16'h0, 1'b1, 8'h00);
        bus_read(2'd2);

        // Read at the control address: no event, DOUT unchanged.
        bus_read(2'd3);
        check("rd_a3_dout_en", {31'b0, DOUT_EN}, 32'd0);
        check("rd_a3_dout_hold", {24'b0, DOUT}, 32'h00);

        // Void accesses: both strobes low, and strobe with CS_N high.
        @(posedge CLK); #1;
        A = 2'd0; DIN = 8'hEE; CS_N = 1'b0; WR_N = 1'b0; RD_N = 1'b0;
        repeat (2) @(posedge CLK);
        #1; WR_N = 1'b1; RD_N = 1'b1; CS_N = 1'b1;
        @(posedge CLK); #1;
        A = 2'd0; DIN = 8'hDD; CS_N = 1'b1; WR_N = 1'b0;
        repeat (2) @(posedge CLK);
        #1; WR_N = 1'b1;
        check("void_dout_en", {31'b0, DOUT_EN}, 32'd0);
        bus_write(2'd0, 8'h56);
        push_exp("load0_after_void", 3'b000, 3'b001, 16'h7856, 1'b0, 8'h00);
        bus_write(2'd0, 8'h78);

        // Control rewrite after a lone LSB resets the write pointer.
        bus_write(2'd0, 8'h99);
        push_exp("cfg0_36", 3'b001, 3'b000, 16'h0, 1'b0, 8'h00);
        bus_write(2'd3, 8'h36);
        check("mode0_after_36", {29'b0, MODE[2:0]}, 32'd3);
        bus_write(2'd0, 8'hCD);
        push_exp("load0_abcd", 3'b000, 3'b001, 16'hABCD, 1'b0, 8'h00);
        bus_write(2'd0, 8'hAB);

        // Counter 1 (RW=01) latch: one LSB read releases it.
        CNT_IN[16 +: 16] = 16'h4242;
        bus_write(2'd3, 8'h40);
        CNT_IN[16 +: 16] = 16'h9999;
        push_exp("rd1_latched", 3'b000, 3'b000, 16'h0, 1'b1, 8'h42);
        bus_read(2'd1);
        push_exp("rd1_live", 3'b000, 3'b000, 16'h0, 1'b1, 8'h99);
        bus_read(2'd1);

        // Reset mid-sequence: held LSB on counter 0, active latch on counter 1.
        bus_write(2'd0, 8'h11);
        CNT_IN[16 +: 16] = 16'h5555;
        bus_write(2'd3, 8'h40);
        @(posedge CLK); #1;
        RESET_N = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        repeat (2) @(posedge CLK);
        #1; RESET_N = 1'b1;
        CNT_IN[16 +: 16] = 16'h1357;
        push_exp("rd1_post_reset_lsb", 3'b000, 3'b000, 16'h0, 1'b1, 8'h57);
        bus_read(2'd1);
        push_exp("rd1_post_reset_msb", 3'b000, 3'b000, 16'h0, 1'b1, 8'h13);
        bus_read(2'd1);
        bus_write(2'd0, 8'h22);
        push_exp("load0_post_reset", 3'b000, 3'b001, 16'h3322, 1'b0, 8'h00);
        bus_write(2'd0, 8'h33);

        repeat (5) @(posedge CLK);
        #1;
        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
